pll_lock_reset_ctrl: RTL and testbench

Consumer-side controller for the `pll` block's lock interface. It drives the PLL's `reset` input and watches the PLL's `extlock` output, qualifying lock over a stable window. It releases the CPU system reset only after lock is qualified, and re-asserts that reset whenever lock is lost. It sits between `pll` and the CPU top, and restarts the PLL if lock does not arrive within a timeout.

---
 rtl/pll_lock_reset_ctrl.sv | 109 ++++++++++
 tb/tb_pll_lock_reset_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_ctrl.sv
// Sequences PLL reset, qualifies a synchronized lock flag over a stable window,
// and releases the CPU system reset only while lock is held.
module pll_lock_reset_ctrl #(
  parameter int unsigned PLL_RST_CYC  = 16,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned CNT_W        = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       extlock,
  input  logic       lock_bypass,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       sys_rst_n,
  output logic       locked,
  output logic [3:0] retry_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             sync1_q, sync2_q;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_q, sys_rst_d;
  logic             locked_q, locked_d;
  logic             lock_ok;

  // Bypass is a static strap, so it joins after the synchronizer.
  assign lock_ok = sync2_q | lock_bypass;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync1_q     <= extlock;
      sync2_q     <= sync1_q;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      locked_q    <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = STABLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = PLL_RST;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
        end
      end
      STABLE: begin
        if (!lock_ok) state_d = WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_ok) state_d = WAIT_LOCK;
      end
      default: state_d = PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they flip on the same edge as state.
  always_comb begin
    pll_reset_d = (state_d == PLL_RST);
    sys_rst_d   = (state_d != RUN);
    locked_d    = (state_d == RUN);
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst   = sys_rst_q;
  assign sys_rst_n = ~sys_rst_q;
  assign locked    = locked_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Directed scenarios plus a randomized lock-toggling phase, each cycle compared
// against a dwell-time reference model of the lock/reset controller.
module tb_pll_lock_reset_ctrl;

  localparam int PRC = 4;
  localparam int STB = 8;
  localparam int TMO = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       extlock = 1'b0;
  logic       lock_bypass = 1'b0;
  logic       pll_reset, sys_rst, sys_rst_n, locked;
  logic [3:0] retry_cnt;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: phase number, edge of phase entry, retry count, and a
  // two-deep history of sampled extlock (oldest first).
  int edge_no = 0;
  int m_state = 0;
  int m_entry = 0;
  int m_retry = 0;
  int h_old = 0;
  int h_new = 0;

  pll_lock_reset_ctrl #(
    .PLL_RST_CYC (PRC),
    .LOCK_STABLE (STB),
    .LOCK_TIMEOUT(TMO),
    .CNT_W       (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .extlock    (extlock),
    .lock_bypass(lock_bypass),
    .pll_reset  (pll_reset),
    .sys_rst    (sys_rst),
    .sys_rst_n  (sys_rst_n),
    .locked     (locked),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int lk, dwell, nxt;
    edge_no++;
    if (reset) begin
      m_state = 0;
      m_entry = edge_no;
      m_retry = 0;
      h_old   = 0;
      h_new   = 0;
      return;
    end
    lk    = h_old | int'(lock_bypass);
    h_old = h_new;
    h_new = int'(extlock);
    dwell = edge_no - 1 - m_entry;
    nxt   = m_state;
    case (m_state)
      0: if (dwell == PRC - 1) nxt = 1;
      1: begin
        if (lk != 0) nxt = 2;
        else if (dwell == TMO - 1) begin
          nxt = 0;
          if (m_retry < 15) m_retry++;
        end
      end
      2: begin
        if (lk == 0) nxt = 1;
        else if (dwell == STB - 1) nxt = 3;
      end
      default: if (lk == 0) nxt = 1;
    endcase
    if (nxt != m_state) begin
      m_state = nxt;
      m_entry = edge_no;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("pll_reset", 32'(pll_reset), 32'(m_state == 0));
    chk("sys_rst", 32'(sys_rst), 32'(m_state != 3));
    chk("sys_rst_n", 32'(sys_rst_n), 32'(m_state == 3));
    chk("locked", 32'(locked), 32'(m_state == 3));
    chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    int len, saw_stable, dropped, pulses;

    // Scenario 1: lock present throughout
    extlock = 1'b1;
    do_reset(3);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 3) chk("s1_pll_high_e3", 32'(pll_reset), 32'd1);
      if (i == 4) chk("s1_pll_low_e4", 32'(pll_reset), 32'd0);
      if (i == 12) chk("s1_sysrst_e12", 32'(sys_rst), 32'd1);
      if (i == 13) chk("s1_sysrst_e13", 32'(sys_rst), 32'd0);
      if (i == 13) chk("s1_locked_e13", 32'(locked), 32'd1);
    end
    chk("s1_retry", 32'(retry_cnt), 32'd0);

    // Scenario 2: no lock ever, retries saturate
    extlock = 1'b0;
    do_reset(2);
    pulses = 0;
    for (int i = 1; i <= 16 * (PRC + TMO) + 20; i++) begin
      step();
      if (i % (PRC + TMO) == 1 && pll_reset) pulses++;
    end
    chk("s2_pulses", 32'(pulses), 32'd17);
    chk("s2_retry_sat", 32'(retry_cnt), 32'd15);
    chk("s2_sysrst", 32'(sys_rst), 32'd1);

    // Scenario 3: short lock glitch during the wait, then solid lock
    do_reset(2);
    repeat (PRC + $urandom_range(0, 10)) step();
    chk("s3_waiting", 32'(state), 32'd1);
    extlock = 1'b1;
    saw_stable = 0;
    dropped = 0;
    repeat (5) begin
      step();
      if (state == 2'd2) saw_stable = 1;
      if (!sys_rst) dropped = 1;
    end
    extlock = 1'b0;
    repeat ($urandom_range(3, 8)) begin
      step();
      if (!sys_rst) dropped = 1;
    end
    chk("s3_saw_stable", 32'(saw_stable), 32'd1);
    chk("s3_aborted", 32'(state), 32'd1);
    chk("s3_no_drop", 32'(dropped), 32'd0);
    extlock = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 10) chk("s3_sysrst_before", 32'(sys_rst), 32'd1);
      if (i == 11) chk("s3_sysrst_fall", 32'(sys_rst), 32'd0);
    end

    // Scenario 4: lock loss in RUN for 20 cycles
    repeat ($urandom_range(1, 20)) step();
    chk("s4_in_run", 32'(state), 32'd3);
    extlock = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (pll_reset) pulses++;
      if (i == 2) chk("s4_sysrst_e1", 32'(sys_rst), 32'd0);
      if (i == 3) chk("s4_sysrst_e2", 32'(sys_rst), 32'd1);
      if (i == 3) chk("s4_locked_e2", 32'(locked), 32'd0);
    end
    extlock = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (pll_reset) pulses++;
      if (i == 10) chk("s4_sysrst_before", 32'(sys_rst), 32'd1);
      if (i == 11) chk("s4_sysrst_fall", 32'(sys_rst), 32'd0);
    end
    chk("s4_no_pll_pulse", 32'(pulses), 32'd0);

    // Scenario 5: bypass strap with dummy PLL
    extlock = 1'b0;
    lock_bypass = 1'b1;
    do_reset(2);
    for (int i = 1; i <= 13; i++) begin
      step();
      if (i == 12) chk("s5_sysrst_e12", 32'(sys_rst), 32'd1);
      if (i == 13) chk("s5_sysrst_e13", 32'(sys_rst), 32'd0);
    end
    dropped = 0;
    repeat ($urandom_range(50, 150)) begin
      step();
      if (sys_rst) dropped = 1;
    end
    chk("s5_stays_low", 32'(dropped), 32'd0);
    lock_bypass = 1'b0;

    // Scenario 6: reset pulse while in RUN with two retries recorded
    do_reset(1);
    repeat (2 * (PRC + TMO) + $urandom_range(1, 30)) step();
    extlock = 1'b1;
    repeat (20) step();
    chk("s6_pre_state", 32'(state), 32'd3);
    chk("s6_pre_retry", 32'(retry_cnt), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s6_pll_reset", 32'(pll_reset), 32'd1);
    chk("s6_sys_rst", 32'(sys_rst), 32'd1);
    chk("s6_locked", 32'(locked), 32'd0);
    chk("s6_retry", 32'(retry_cnt), 32'd0);
    chk("s6_state", 32'(state), 32'd0);

    // Randomized phase: lock toggling, occasional bypass and resets
    for (int s = 0; s < 60; s++) begin
      extlock = 1'($urandom_range(0, 1));
      lock_bypass = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) do_reset(1);
      len = $urandom_range(1, 60);
      repeat (len) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
